// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Initiator side of the 16-bit ALU interface in the execute stage. Accepts one
//   command per valid/ready handshake and registers its operands and opcode onto
//   the combinational ALU. After ALU_LAT cycles it captures res/szcv, updates the
//   architectural SZCV flag register when asked, evaluates the branch condition
//   and presents the result on a valid/ready response channel.
//
//   Parameters
//     ALU_LAT    cycles from operand drive to res/szcv capture (1..15)
//     FLAG_RESET flag register value after reset
//
//   Ports
//     clk, rst                          clock, synchronous active-high reset
//     cmd_valid/cmd_ready               command handshake
//     cmd_op/cmd_a/cmd_b                opcode and operands
//     cmd_wflag                         update flags from this command's szcv
//     cmd_cond                          branch condition (BE/BLT/BLE/BNE/ALWAYS/NEVER)
//     alu_a/alu_b/alu_op                registered operands/opcode to the ALU
//     alu_res/alu_szcv                  ALU result and {S,Z,C,V}
//     rsp_valid/rsp_ready               response handshake
//     rsp_res/rsp_wr/rsp_taken          captured result, write-back, branch taken
//     flags                             current flag register {S,Z,C,V}
module alu_issue_ctrl #(
  parameter int unsigned ALU_LAT    = 1,
  parameter logic [3:0]  FLAG_RESET = 4'b0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  input  logic        cmd_wflag,
  input  logic [2:0]  cmd_cond,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [15:0] alu_res,
  input  logic [3:0]  alu_szcv,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_res,
  output logic        rsp_wr,
  output logic        rsp_taken,
  output logic [3:0]  flags
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        wflag_q;
  logic [2:0]  cond_q;
  logic        accept;
  logic        rsp_hs;
  logic        capture;
  logic [3:0]  flags_new;

  // Branch condition on {S,Z,C,V}.
  function automatic logic cond_true(input logic [2:0] cond, input logic [3:0] f);
    logic s, z, v;
    s = f[3];
    z = f[2];
    v = f[0];
    case (cond)
      3'b000:  return z;
      3'b001:  return s ^ v;
      3'b010:  return z | (s ^ v);
      3'b011:  return ~z;
      3'b100:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // CMP (0101) and the undefined codes produce no write-back.
  function automatic logic op_writes(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
      4'b0110, 4'b1000, 4'b1001, 4'b1010, 4'b1011: return 1'b1;
      default:                                     return 1'b0;
    endcase
  endfunction

  assign accept    = cmd_valid & cmd_ready;
  assign rsp_hs    = rsp_valid & rsp_ready;
  assign capture   = (state == EXEC) && (cnt == 4'd0);
  // Branch is evaluated against the flags as they will be after this capture.
  assign flags_new = wflag_q ? alu_szcv : flags;

  // State register
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments in clocked blocks so every register
    // samples pre-edge values regardless of statement order.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned
    // (which would infer a latch).
    state_nxt = state;
    case (state)
      IDLE:    if (accept)  state_nxt = EXEC;
      EXEC:    if (capture) state_nxt = RESP;
      RESP:    if (rsp_hs)  state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  // Outputs; reset masks both handshakes so an aborted operation never responds.
  always_comb begin
    cmd_ready = (state == IDLE) && !rst;
    rsp_valid = (state == RESP) && !rst;
  end

  // Datapath: operand registers, latency counter, capture and flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      cnt       <= '0;
      wflag_q   <= 1'b0;
      cond_q    <= '0;
      rsp_res   <= '0;
      rsp_wr    <= 1'b0;
      rsp_taken <= 1'b0;
      flags     <= FLAG_RESET;
    end else begin
      if (accept) begin
        alu_a   <= cmd_a;
        alu_b   <= cmd_b;
        alu_op  <= cmd_op;
        wflag_q <= cmd_wflag;
        cond_q  <= cmd_cond;
        cnt     <= LAT_M1;
      end
      if (state == EXEC) begin
        if (cnt == 4'd0) begin
          rsp_res   <= alu_res;
          rsp_wr    <= op_writes(alu_op);
          rsp_taken <= cond_true(cond_q, flags_new);
          flags     <= flags_new;
        end else begin
          cnt <= cnt - 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  cmd_op;
  logic [15:0] cmd_a, cmd_b;
  logic        cmd_wflag;
  logic [2:0]  cmd_cond;

  // DUT with ALU_LAT = 1
  logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_wr, rsp_taken;
  logic [15:0] alu_a, alu_b, alu_res, rsp_res;
  logic [3:0]  alu_op, alu_szcv, flags;

  // DUT with ALU_LAT = 3
  logic        cmd_valid3, cmd_ready3, rsp_valid3, rsp_ready3, rsp_wr3, rsp_taken3;
  logic [15:0] alu_a3, alu_b3, alu_res3, rsp_res3;
  logic [3:0]  alu_op3, alu_szcv3, flags3;

  int vectors    = 0;
  int miscompares = 0;
  int lat_n;

  alu_issue_ctrl #(.ALU_LAT(1), .FLAG_RESET(4'b0000)) u_dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_wflag(cmd_wflag), .cmd_cond(cmd_cond),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_res(alu_res), .alu_szcv(alu_szcv),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res(rsp_res),
    .rsp_wr(rsp_wr), .rsp_taken(rsp_taken), .flags(flags)
  );

  alu_issue_ctrl #(.ALU_LAT(3), .FLAG_RESET(4'b0000)) u_dut3 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_wflag(cmd_wflag), .cmd_cond(cmd_cond),
    .alu_a(alu_a3), .alu_b(alu_b3), .alu_op(alu_op3),
    .alu_res(alu_res3), .alu_szcv(alu_szcv3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_res(rsp_res3),
    .rsp_wr(rsp_wr3), .rsp_taken(rsp_taken3), .flags(flags3)
  );

  // Stand-in for the external combinational ALU: {szcv, res}.
  function automatic logic [19:0] alu_f(input logic [3:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
    logic [16:0] r;
    logic        c, v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      4'b0000: begin
        r = {1'b0, a} + {1'b0, b};
        c = r[16];
        v = (a[15] == b[15]) && (r[15] != a[15]);
      end
      4'b0001, 4'b0101: begin
        r = {1'b0, a} - {1'b0, b};
        c = (a < b);
        v = (a[15] != b[15]) && (r[15] != a[15]);
      end
      4'b0010: r = {1'b0, a & b};
      4'b0011: r = {1'b0, a | b};
      4'b0100: r = {1'b0, a ^ b};
      default: r = '0;
    endcase
    return {r[15], (r[15:0] == 16'h0000), c, v, r[15:0]};
  endfunction

  always_comb begin
    {alu_szcv, alu_res}   = alu_f(alu_op, alu_a, alu_b);
    {alu_szcv3, alu_res3} = alu_f(alu_op3, alu_a3, alu_b3);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one command to the ALU_LAT=1 DUT and check the response it presents.
  task automatic issue(input string tag, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic wf, input logic [2:0] cond,
                       input logic [15:0] e_res, input logic e_wr, input logic e_tk,
                       input logic [3:0] e_fl);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    cmd_wflag = wf; cmd_cond = cond;
    check({tag, ".cmd_ready"}, 32'(cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check({tag, ".alu_a"}, 32'(alu_a), 32'(a));
    check({tag, ".alu_op"}, 32'(alu_op), 32'(op));
    lat_n = 1;
    while (!rsp_valid && lat_n < 20) begin
      @(negedge clk);
      lat_n++;
    end
    check({tag, ".latency"}, 32'(lat_n), 32'd2);
    check({tag, ".rsp_res"}, 32'(rsp_res), 32'(e_res));
    check({tag, ".rsp_wr"}, 32'(rsp_wr), 32'(e_wr));
    check({tag, ".rsp_taken"}, 32'(rsp_taken), 32'(e_tk));
    check({tag, ".flags"}, 32'(flags), 32'(e_fl));
    check({tag, ".cmd_ready_busy"}, 32'(cmd_ready), 32'd0);
  endtask

  // Complete the response handshake; called at a negedge with rsp_valid high.
  task automatic release_rsp(input string tag);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, ".rsp_valid_after_hs"}, 32'(rsp_valid), 32'd0);
    check({tag, ".cmd_ready_after_hs"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_valid3 = 1'b0; rsp_ready3 = 1'b0;
    cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_wflag = 1'b0; cmd_cond = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst.flags", 32'(flags), 32'h0);
    check("rst.alu_a", 32'(alu_a), 32'h0);
    check("rst.rsp_res", 32'(rsp_res), 32'h0);
    rst = 1'b0;
    #1;
    check("idle.cmd_ready", 32'(cmd_ready), 32'd1);

    // 1: ADD overflow into sign, BLT with S^V = 0
    issue("add_ovf", 4'b0000, 16'h7FFF, 16'h0001, 1'b1, 3'b001,
          16'h8000, 1'b1, 1'b0, 4'b1001);
    release_rsp("add_ovf");

    // 2: CMP 3-5 sets S and borrow, no write-back, BLT taken
    issue("cmp_lt", 4'b0101, 16'h0003, 16'h0005, 1'b1, 3'b001,
          16'hFFFE, 1'b0, 1'b1, 4'b1010);
    release_rsp("cmp_lt");

    // 3: SUB to zero without flag update; BE sees held Z=0
    issue("sub_nowf", 4'b0001, 16'h0005, 16'h0005, 1'b0, 3'b000,
          16'h0000, 1'b1, 1'b0, 4'b1010);
    release_rsp("sub_nowf");

    // 4: response backpressure with a second command pending
    issue("bp", 4'b0001, 16'h0009, 16'h0002, 1'b0, 3'b010,
          16'h0007, 1'b1, 1'b1, 4'b1010);
    cmd_valid = 1'b1; cmd_op = 4'b0000; cmd_a = 16'h1111; cmd_b = 16'h1111;
    cmd_wflag = 1'b1; cmd_cond = 3'b100;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp.rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp.rsp_res", 32'(rsp_res), 32'h0007);
      check("bp.rsp_taken", 32'(rsp_taken), 32'd1);
      check("bp.cmd_ready", 32'(cmd_ready), 32'd0);
      check("bp.alu_a", 32'(alu_a), 32'h0009);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    check("bp.hs_no_accept", 32'(alu_a), 32'h0009);
    check("bp.idle_ready", 32'(cmd_ready), 32'd1);
    check("bp.flags_held", 32'(flags), 32'b1010);
    @(posedge clk);
    @(negedge clk);
    check("bp.still_idle", 32'(alu_a), 32'h0009);

    // AND with flag update, ALWAYS
    issue("and_alw", 4'b0010, 16'h0F0F, 16'h00FF, 1'b1, 3'b100,
          16'h000F, 1'b1, 1'b1, 4'b0000);
    release_rsp("and_alw");

    // Undefined opcode: issued, updates flags, no write-back, BE on new Z
    issue("undef", 4'b0111, 16'h1234, 16'h0001, 1'b1, 3'b000,
          16'h0000, 1'b0, 1'b1, 4'b0100);
    release_rsp("undef");

    // OR without flag update, BNE with held Z=1
    issue("or_bne", 4'b0011, 16'h0000, 16'h0000, 1'b0, 3'b011,
          16'h0000, 1'b1, 1'b0, 4'b0100);
    release_rsp("or_bne");

    // 11xx opcode, NEVER
    issue("op11_never", 4'b1100, 16'hAAAA, 16'h5555, 1'b0, 3'b110,
          16'h0000, 1'b0, 1'b0, 4'b0100);
    release_rsp("op11_never");

    // 5: ALU_LAT=3 latency and result
    @(negedge clk);
    cmd_valid3 = 1'b1; cmd_op = 4'b0000; cmd_a = 16'h0001; cmd_b = 16'h0002;
    cmd_wflag = 1'b0; cmd_cond = 3'b100;
    @(posedge clk);
    @(negedge clk);
    cmd_valid3 = 1'b0;
    lat_n = 1;
    while (!rsp_valid3 && lat_n < 20) begin
      @(negedge clk);
      lat_n++;
    end
    check("lat3.latency", 32'(lat_n), 32'd4);
    check("lat3.rsp_res", 32'(rsp_res3), 32'h0003);
    check("lat3.rsp_taken", 32'(rsp_taken3), 32'd1);
    rsp_ready3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready3 = 1'b0;
    check("lat3.rsp_valid_after_hs", 32'(rsp_valid3), 32'd0);

    // 6: reset during EXEC aborts the operation
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 4'b0000; cmd_a = 16'h8000; cmd_b = 16'h8000;
    cmd_wflag = 1'b1; cmd_cond = 3'b100;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("abort.cmd_ready_in_rst", 32'(cmd_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort.rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort.flags", 32'(flags), 32'h0);
    check("abort.cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("abort.no_late_rsp", 32'(rsp_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
